// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-4 demultiplexer.
package demux_pkg;

  // Channel select codes, {S1_in,S0_in}
  typedef enum logic [1:0] {
    CH_A = 2'b00,
    CH_B = 2'b01,
    CH_C = 2'b10,
    CH_D = 2'b11
  } chan_e;

  localparam int NUM_CH    = 4;
  localparam int DEF_WIDTH = 4;

  // Rejected-write counter geometry
  localparam int                  DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

  // Select code to one-hot channel mask (bit0=A ... bit3=D)
  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [1:0] sel);
    logic [NUM_CH-1:0] mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One demultiplexer channel: holds a word plus an occupied flag until acked.
// A write in the same cycle as an ack wins: new data is loaded and the
// channel stays occupied.
module demux_chan_reg #(
  parameter int WIDTH = 4
) (
  input  logic             Clk_in,
  input  logic             Rst_in,
  input  logic             wr_en,
  input  logic             ack,
  input  logic [WIDTH-1:0] Data_in,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // Channel storage: load on write, otherwise release on ack
  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (wr_en) begin
      data  <= Data_in;
      valid <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_14_4bit_reg.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ack handshake.
// Writes to an occupied, un-acked channel are rejected and flagged on Drop_out.
// Optional build macro DEMUX_DROP_CNT_EN adds Drop_cnt_out, a saturating
// count of rejected writes.
module demux_14_4bit_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             Clk_in,
  input  logic             Rst_in,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             S0_in,
  input  logic             S1_in,
  input  logic             Load_in,
  input  logic [3:0]       Ack_in,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic [WIDTH-1:0] C_out,
  output logic [WIDTH-1:0] D_out,
  output logic [3:0]       Valid_out,
  output logic             Ready_out,
  output logic             Drop_out
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] Drop_cnt_out
`endif
);

  logic [1:0]        sel;
  logic [NUM_CH-1:0] sel_mask;
  logic [NUM_CH-1:0] wr_en;
  logic              accept;
  logic              reject;
  logic [WIDTH-1:0]  chan_data [NUM_CH];

  // Select decode, readiness of the selected channel and write steering
  always_comb begin
    sel       = {S1_in, S0_in};
    sel_mask  = sel_onehot(sel);
    Ready_out = ~Valid_out[sel] | Ack_in[sel];
    accept    = Load_in & Ready_out;
    reject    = Load_in & ~Ready_out;
    wr_en     = accept ? sel_mask : '0;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    demux_chan_reg #(
      .WIDTH (WIDTH)
    ) u_chan (
      .Clk_in  (Clk_in),
      .Rst_in  (Rst_in),
      .wr_en   (wr_en[i]),
      .ack     (Ack_in[i]),
      .Data_in (Data_in),
      .data    (chan_data[i]),
      .valid   (Valid_out[i])
    );
  end

  assign A_out = chan_data[CH_A];
  assign B_out = chan_data[CH_B];
  assign C_out = chan_data[CH_C];
  assign D_out = chan_data[CH_D];

  // One-cycle pulse following each rejected write
  always_ff @(posedge Clk_in) begin
    if (Rst_in) Drop_out <= 1'b0;
    else        Drop_out <= reject;
  end

`ifdef DEMUX_DROP_CNT_EN
  // Saturating rejected-write counter, advances on the edge that raises Drop_out
  always_ff @(posedge Clk_in) begin
    if (Rst_in)
      Drop_cnt_out <= '0;
    else if (reject && (Drop_cnt_out != DROP_CNT_MAX))
      Drop_cnt_out <= Drop_cnt_out + DROP_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_demux_14_4bit_reg.sv
// Directed bench for demux_14_4bit_reg: a behavioural model computes the
// expected state for every step and pushes it to a scoreboard queue, which is
// popped and compared after the clock edge that produces it.
module tb_demux_14_4bit_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data;
  logic       s0, s1;
  logic       load;
  logic [3:0] ack;
  logic [3:0] a_q, b_q, c_q, d_q;
  logic [3:0] valid;
  logic       ready;
  logic       drop;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  demux_14_4bit_reg #(.WIDTH(4)) dut (
    .Clk_in    (clk),
    .Rst_in    (rst),
    .Data_in   (data),
    .S0_in     (s0),
    .S1_in     (s1),
    .Load_in   (load),
    .Ack_in    (ack),
    .A_out     (a_q),
    .B_out     (b_q),
    .C_out     (c_q),
    .D_out     (d_q),
    .Valid_out (valid),
    .Ready_out (ready),
    .Drop_out  (drop)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .Drop_cnt_out (drop_cnt)
`endif
  );

`ifndef DEMUX_DROP_CNT_EN
  assign drop_cnt = 8'd0;
`endif

  typedef struct {
    logic [3:0] a, b, c, d;
    logic [3:0] v;
    logic       drop;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [3:0] m_data [4];
  logic [3:0] m_valid;
  logic       m_drop;
  logic [7:0] m_cnt;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic ld,
                      input logic [1:0] sel, input logic [3:0] d, input logic [3:0] ak);
    exp_t e;
    logic rdy;
    rst  = r;
    load = ld;
    {s1, s0} = sel;
    data = d;
    ack  = ak;
    #1;
    rdy = !m_valid[sel] || ak[sel];
    if (!r) chk({tag, ".ready"}, {7'd0, ready}, {7'd0, rdy});
    if (r) begin
      for (int i = 0; i < 4; i++) m_data[i] = 4'h0;
      m_valid = 4'b0000;
      m_drop  = 1'b0;
      m_cnt   = 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ld && rdy && (sel == i[1:0])) begin
          m_data[i]  = d;
          m_valid[i] = 1'b1;
        end else if (ak[i]) begin
          m_valid[i] = 1'b0;
        end
      end
      m_drop = ld && !rdy;
`ifdef DEMUX_DROP_CNT_EN
      if (m_drop && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
`endif
    end
    e.a = m_data[0]; e.b = m_data[1]; e.c = m_data[2]; e.d = m_data[3];
    e.v = m_valid; e.drop = m_drop; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".A"},     {4'd0, a_q},   {4'd0, e.a});
    chk({tag, ".B"},     {4'd0, b_q},   {4'd0, e.b});
    chk({tag, ".C"},     {4'd0, c_q},   {4'd0, e.c});
    chk({tag, ".D"},     {4'd0, d_q},   {4'd0, e.d});
    chk({tag, ".valid"}, {4'd0, valid}, {4'd0, e.v});
    chk({tag, ".drop"},  {7'd0, drop},  {7'd0, e.drop});
`ifdef DEMUX_DROP_CNT_EN
    chk({tag, ".cnt"},   drop_cnt,      e.cnt);
`endif
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data = 4'h0; s0 = 1'b0; s1 = 1'b0; ack = 4'h0;
    for (int i = 0; i < 4; i++) m_data[i] = 4'h0;
    m_valid = 4'b0; m_drop = 1'b0; m_cnt = 8'd0;
    @(posedge clk);
    #1;

    // Reset held two cycles with a pending write
    step("rst0", 1'b1, 1'b1, 2'b00, 4'hF, 4'h0);
    step("rst1", 1'b1, 1'b1, 2'b00, 4'hF, 4'h0);
    chk("rst.valid_const", {4'd0, valid}, 8'h00);

    // Route one word to each channel, back to back
    step("routeA", 1'b0, 1'b1, 2'b00, 4'h1, 4'h0);
    step("routeB", 1'b0, 1'b1, 2'b01, 4'h2, 4'h0);
    step("routeC", 1'b0, 1'b1, 2'b10, 4'h4, 4'h0);
    step("routeD", 1'b0, 1'b1, 2'b11, 4'h8, 4'h0);
    chk("route.valid_all", {4'd0, valid}, 8'h0F);

    // Ack and write A together: write wins, A now holds 3
    step("ackwrA", 1'b0, 1'b1, 2'b00, 4'h3, 4'b0001);
    // Reject on full channel A
    step("rejA",   1'b0, 1'b1, 2'b00, 4'h9, 4'h0);
    chk("rejA.A_held", {4'd0, a_q}, 8'h03);
    step("idle0",  1'b0, 1'b0, 2'b00, 4'h0, 4'h0);

    // Ack alone, then refill A
    step("ackA",   1'b0, 1'b0, 2'b00, 4'h0, 4'b0001);
    step("ackA2",  1'b0, 1'b0, 2'b00, 4'h0, 4'b0001);
    step("wrA6",   1'b0, 1'b1, 2'b00, 4'h6, 4'h0);

    // Simultaneous ack and write on B
    step("ackwrB", 1'b0, 1'b1, 2'b01, 4'hA, 4'b0010);

    // Select wiggle without Load has no effect
    step("selC",   1'b0, 1'b0, 2'b10, 4'h5, 4'h0);
    step("selD",   1'b0, 1'b0, 2'b11, 4'hE, 4'h0);

    // Ack on C while writing D after acking D; C/D independent
    step("ackD",   1'b0, 1'b0, 2'b00, 4'h0, 4'b1000);
    step("wrD_ackC", 1'b0, 1'b1, 2'b11, 4'hC, 4'b0100);
    step("wrC",    1'b0, 1'b1, 2'b10, 4'h7, 4'h0);
    step("rejC",   1'b0, 1'b1, 2'b10, 4'h1, 4'h0);
    step("rejD",   1'b0, 1'b1, 2'b11, 4'h2, 4'h0);
    step("idle1",  1'b0, 1'b0, 2'b00, 4'h0, 4'h0);

    // Mid-operation reset discards all words
    step("midrst", 1'b1, 1'b1, 2'b01, 4'hB, 4'b1111);
    step("postA",  1'b0, 1'b1, 2'b00, 4'hD, 4'h0);

`ifdef DEMUX_DROP_CNT_EN
    // Saturation of the rejected-write counter
    for (int k = 0; k < 300; k++)
      step("sat", 1'b0, 1'b1, 2'b00, 4'h4, 4'h0);
    chk("sat.cnt255", drop_cnt, 8'd255);
    step("cntrst", 1'b1, 1'b0, 2'b00, 4'h0, 4'h0);
    chk("cntrst.zero", drop_cnt, 8'd0);
`else
    for (int k = 0; k < 5; k++)
      step("rejrun", 1'b0, 1'b1, 2'b00, 4'h4, 4'h0);
`endif
    step("final", 1'b0, 1'b0, 2'b00, 4'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_14_4bit_reg.md
Name: demux_14_4bit_reg

Overview:
- Registered 1-to-4 demultiplexer, the counterpart of the 4:1 4-bit mux.
- Routes one 4-bit source word to one of four channel registers A..D, selected by S1_in:S0_in.
- Each channel holds its word with a valid flag until its consumer acknowledges it.
- Writes to an occupied channel are rejected and flagged, so the source never overwrites unread data.

Parameters:
WIDTH, 4, data width of the source word and each channel register

Ports:
Clk_in  input  1  system clock; all state updates on its rising edge
Rst_in  input  1  synchronous reset, active-high
Data_in  input  WIDTH  source word
S0_in  input  1  select bit 0
S1_in  input  1  select bit 1; {S1_in,S0_in}: 00=A, 01=B, 10=C, 11=D
Load_in  input  1  write strobe; one write request per cycle while high
Ack_in  input  4  per-channel consume strobe; bit0=A … bit3=D
A_out  output  WIDTH  channel A register
B_out  output  WIDTH  channel B register
C_out  output  WIDTH  channel C register
D_out  output  WIDTH  channel D register
Valid_out  output  4  per-channel occupied flag; bit0=A … bit3=D
Ready_out  output  1  combinational; selected channel can accept a write this cycle
Drop_out  output  1  registered one-cycle pulse; a write was rejected

Behaviour:
- Reset: synchronous and active-high; sampled on the rising edge of Clk_in. When Rst_in=1 at an edge:
  - A_out..D_out = 0, Valid_out = 0, Drop_out = 0.
  - Reset dominates Load_in and Ack_in in the same cycle.
  - A reset asserted mid-operation discards all held words.
- Ready_out = ~Valid_out[sel] | Ack_in[sel].
- Accepted write: Load_in=1 and Ready_out=1 at an edge.
  - The selected channel register takes Data_in and its Valid bit is set.
  - Latency is 1 cycle; the word is visible on the output the cycle after the strobe.
- Rejected write: Load_in=1 and Ready_out=0.
  - The channel register and Valid bit are unchanged.
  - Drop_out=1 for exactly the next cycle.
- Ack only: Ack_in[i]=1 with no accepted write to i clears Valid_out[i]. The data register keeps its last value.
- Ack and write to the same channel in the same cycle: the write wins. New data is loaded, Valid stays 1, and no drop is flagged.
- Acks on non-selected channels are processed independently in the same cycle as a write to another channel.
- An ack to an empty channel is a no-op.
- Select bits are sampled only when Load_in=1. Changing the select bits with Load_in=0 has no effect.
- Back-to-back writes to different empty channels are accepted on consecutive cycles; there is no bubble.
- Data registers update only on an accepted write; outputs never glitch to Data_in otherwise.
- Drop_out is 0 in every cycle not following a rejection.

Optional Feature:
- Macro: DEMUX_DROP_CNT_EN.
- Defined:
  - Adds output port Drop_cnt_out (8 bits).
  - It is a saturating count of rejected writes: +1 per rejection, holds at 255.
  - Cleared by Rst_in.
  - Updates in the same edge that raises Drop_out.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg:
  - Channel index constants CH_A=2'b00, CH_B=2'b01, CH_C=2'b10, CH_D=2'b11.
  - Default WIDTH=4.
  - DROP_CNT_W=8 and DROP_CNT_MAX=255.
- Sub-module demux_chan_reg, instantiated four times:
  - Inputs: Clk_in, Rst_in, write-enable, ack, Data_in.
  - Outputs: data register and valid flag.
  - Implements the write-wins-over-ack rule locally.
- Top level:
  - Decodes the select bits.
  - Forms Ready_out and per-channel write enables.
  - Generates Drop_out and the optional counter.

Test Plan:
- Reset: hold Rst_in=1 for 2 cycles with Load_in=1, Data_in=4'hF -> all outputs 0, Valid_out=4'b0000, Drop_out=0.
- Route each channel:
  - Stimulus, one per cycle: Data_in=1 with sel=00, 2 with sel=01, 4 with sel=10, 8 with sel=11.
  - Response: A_out=1, B_out=2, C_out=4, D_out=8; Valid_out=4'b1111 one cycle after the last write.
- Reject on full: channel A holds 4'h3; write 4'h9 to sel=00 without ack.
  - Ready_out=0 during the strobe.
  - A_out stays 3.
  - Drop_out=1 for one cycle, then 0.
- Ack then write:
  - Ack_in=4'b0001 alone -> Valid_out[0]=0 and A_out unchanged.
  - Then write 4'h6 to A -> A_out=6, Valid_out[0]=1.
- Simultaneous ack and write: channel B holds 4'h2; Ack_in[1]=1 and write 4'hA to sel=01 in the same cycle -> B_out=A, Valid_out[1]=1, Drop_out=0.
- DEMUX_DROP_CNT_EN build:
  - 300 rejected writes -> Drop_cnt_out saturates at 255.
  - Rst_in -> Drop_cnt_out=0.
